// File: rtl/ref_stream_pkg.sv
// ref_stream_pkg
//   Shared constants, FSM state type and column packing helper for the
//   reference-column streamer (ref_column_streamer / ref_col_packer).
package ref_stream_pkg;

    localparam int unsigned BIT_DEPTH  = 8;
    localparam int unsigned COL_HEIGHT = 23;
    localparam int unsigned WORD_PIX   = 8;
    localparam int unsigned SEGS       = 3;
    localparam int unsigned WIN_COLS   = 23;
    localparam int unsigned ADDR_W     = 16;

    localparam int unsigned WORD_W    = WORD_PIX * BIT_DEPTH;   // 64
    localparam int unsigned COL_W     = COL_HEIGHT * BIT_DEPTH; // 184
    localparam int unsigned PACK_W    = SEGS * WORD_W;          // 192
    localparam int unsigned CREDITS   = 2 * SEGS;
    localparam int unsigned NREQ      = SEGS * WIN_COLS;

    localparam int unsigned FILL_W    = $clog2(SEGS + 1);
    localparam int unsigned SEG_W     = $clog2(SEGS);
    localparam int unsigned COL_IDX_W = $clog2(WIN_COLS);
    localparam int unsigned REQ_W     = $clog2(NREQ);
    localparam int unsigned OUT_W     = $clog2(CREDITS + 1);
    localparam int unsigned CRED_W    = $clog2(3 * CREDITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Segment 0 sits in the top bytes; the surplus low byte of the last
    // segment lies below the column and is dropped.
    function automatic logic [COL_W-1:0] pack_column(input logic [PACK_W-1:0] pack);
        return pack[PACK_W-1 -: COL_W];
    endfunction

endpackage

// File: rtl/ref_col_packer.sv
// ref_col_packer
//   Collects SEGS memory words into a pack register, moves full packs into
//   the output register and presents them over valid/ready.
//   Ports:
//     clk_i, rst_i        clock, async active-high reset
//     clear_i             restart column numbering (window start)
//     rsp_valid_i/data_i  accepted memory response word
//     fill_o              words currently held in the pack register
//     data_o/valid_o      output column and its valid
//     ready_i             downstream accept
//     last_o              output column is the final one of the window
//     last_hs_o           final column handshakes this cycle
module ref_col_packer
    import ref_stream_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              rsp_valid_i,
    input  logic [WORD_W-1:0] rsp_data_i,
    output logic [FILL_W-1:0] fill_o,
    output logic [COL_W-1:0]  data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              last_hs_o
);

    logic [PACK_W-1:0]    pack_q, pack_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [COL_W-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic [COL_IDX_W-1:0] col_q, col_d;
    logic                 move;
    logic [FILL_W-1:0]    wr_idx;

    always_comb begin
        pack_d  = pack_q;
        fill_d  = fill_q;
        data_d  = data_q;
        valid_d = valid_q;
        col_d   = col_q;
        move    = (fill_q == FILL_W'(SEGS)) && (!valid_q || ready_i);

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            col_d   = col_q + 1'b1;
        end
        if (move) begin
            data_d  = pack_column(pack_q);
            valid_d = 1'b1;
            fill_d  = '0;
        end

        // A response on the same edge as a move starts the fresh pack.
        wr_idx = move ? '0 : fill_q;
        if (rsp_valid_i) begin
            for (int unsigned s = 0; s < SEGS; s++) begin
                if (wr_idx == FILL_W'(s)) begin
                    pack_d[(SEGS-1-s)*WORD_W +: WORD_W] = rsp_data_i;
                end
            end
            fill_d = wr_idx + 1'b1;
        end

        if (clear_i) begin
            col_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pack_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            col_q   <= '0;
        end else begin
            pack_q  <= pack_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            col_q   <= col_d;
        end
    end

    assign fill_o    = fill_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign last_o    = valid_q && (col_q == COL_IDX_W'(WIN_COLS - 1));
    assign last_hs_o = last_o && ready_i;

endmodule

// File: rtl/ref_column_streamer.sv
// ref_column_streamer
//   Walks one search window of reference memory column by column, fetching
//   SEGS words per column and streaming packed columns over valid/ready.
//   Ports:
//     clk_i, rst_i              clock, async active-high reset
//     start_i                   begin a window (ignored unless idle)
//     base_addr_i, stride_i     column-0 address and column step, sampled on start
//     mem_rd_o, mem_addr_o      read request, held until mem_ready_i
//     mem_ready_i               request accepted
//     mem_rdata_i, mem_rvalid_i in-order read response
//     data_o, valid_o, ready_i  packed column stream
//     last_o                    final column of the window
//     busy_o                    window in progress
//     done_o                    one-cycle pulse after the final column is taken
//     stall_cnt_o               (only with REF_STREAM_STATS_EN) cycles with
//                               valid_o && !ready_i, saturating
module ref_column_streamer
    import ref_stream_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic [COL_W-1:0]  data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef REF_STREAM_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   col_base_q, col_base_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [REQ_W-1:0]    req_cnt_q, req_cnt_d;
    logic [OUT_W-1:0]    outst_q, outst_d;

    logic                start_acc;
    logic                req_acc;
    logic                rsp_acc;
    logic                credit_ok;
    logic                last_hs;
    logic [FILL_W-1:0]   fill;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign req_acc   = mem_rd_o && mem_ready_i;
    // Responses with nothing outstanding are stale (e.g. issued before reset).
    assign rsp_acc   = mem_rvalid_i && (outst_q != '0);
    // The credit sum only grows on request acceptance, so once a request is
    // raised it stays raised until taken.
    assign credit_ok = (CRED_W'(outst_q) + CRED_W'(fill)
                        + (valid_o ? CRED_W'(SEGS) : '0)) < CRED_W'(CREDITS);
    assign mem_addr_o = col_base_q + ADDR_W'(seg_q);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_FETCH;
            ST_FETCH: if (req_acc && (req_cnt_q == REQ_W'(NREQ - 1))) state_d = ST_DRAIN;
            ST_DRAIN: if (last_hs) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_rd_o = (state_q == ST_FETCH) && credit_ok;
        busy_o   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        done_o   = (state_q == ST_DONE);
    end

    // Address generation and outstanding-request tracking
    always_comb begin
        stride_d   = stride_q;
        col_base_d = col_base_q;
        seg_d      = seg_q;
        req_cnt_d  = req_cnt_q;
        if (start_acc) begin
            stride_d   = stride_i;
            col_base_d = base_addr_i;
            seg_d      = '0;
            req_cnt_d  = '0;
        end else if (req_acc) begin
            req_cnt_d = req_cnt_q + 1'b1;
            if (seg_q == SEG_W'(SEGS - 1)) begin
                seg_d      = '0;
                col_base_d = col_base_q + stride_q;
            end else begin
                seg_d = seg_q + 1'b1;
            end
        end
        outst_d = outst_q + OUT_W'(req_acc) - OUT_W'(rsp_acc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stride_q   <= '0;
            col_base_q <= '0;
            seg_q      <= '0;
            req_cnt_q  <= '0;
            outst_q    <= '0;
        end else begin
            stride_q   <= stride_d;
            col_base_q <= col_base_d;
            seg_q      <= seg_d;
            req_cnt_q  <= req_cnt_d;
            outst_q    <= outst_d;
        end
    end

    ref_col_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_acc),
        .rsp_valid_i (rsp_acc),
        .rsp_data_i  (mem_rdata_i),
        .fill_o      (fill),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .last_hs_o   (last_hs)
    );

`ifdef REF_STREAM_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ref_column_streamer.sv
// tb_ref_column_streamer
//   Randomized self-checking bench for ref_column_streamer with a latency
//   and acceptance configurable memory model and a per-pixel column model.
module tb_ref_column_streamer;
    import ref_stream_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] stride_i;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ready_i;
    logic [WORD_W-1:0] mem_rdata_i;
    logic              mem_rvalid_i;
    logic [COL_W-1:0]  data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic              busy_o;
    logic              done_o;
`ifdef REF_STREAM_STATS_EN
    logic [31:0]       stall_cnt_o;
`endif

    ref_column_streamer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .stride_i     (stride_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef REF_STREAM_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Window / environment configuration shared with the model process
    logic [15:0] win_base   = '0;
    logic [15:0] win_stride = '0;
    int unsigned lat        = 1;
    bit          mem_rand   = 0;
    bit          rdy_rand   = 0;
    int unsigned stall_req  = 0;

    // Scoreboard state
    int unsigned ncol = 0, nreq = 0, stall_seen = 0, max_outst = 0, last_hs_cyc = 0;
    logic [COL_W-1:0] exp_col [WIN_COLS];
    bit               hold_prev = 0;
    logic [COL_W-1:0] prev_data;

    typedef struct {
        logic [15:0] addr;
        int unsigned due;
    } rsp_t;
    rsp_t rq[$];

    // Memory content: 8 distinct bytes per word, MSB byte is pixel 0.
    function automatic logic [WORD_W-1:0] mem_word(input logic [15:0] a);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[63-8*k -: 8] = (a[7:0] + 8'(k * 41)) ^ (a[15:8] * 8'd7);
        end
        return w;
    endfunction

    function automatic logic [15:0] exp_addr(input int unsigned i);
        return win_base + 16'(i / SEGS) * win_stride + 16'(i % SEGS);
    endfunction

    // Pixel-by-pixel column: row r is pixel r%8 of word at column address + r/8.
    task automatic build_expected();
        logic [15:0]       a;
        logic [WORD_W-1:0] w;
        for (int c = 0; c < WIN_COLS; c++) begin
            for (int r = 0; r < COL_HEIGHT; r++) begin
                a = win_base + 16'(c) * win_stride + 16'(r / 8);
                w = mem_word(a);
                exp_col[c][COL_W-1-8*r -: 8] = w[63-8*(r%8) -: 8];
            end
        end
    endtask

    // Memory model, downstream sink and output monitor (acts 1 time unit after negedge)
    initial begin
        rsp_t r;
        ready_i      = 1'b1;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (stall_req > 0) begin
                ready_i = 1'b0;
                stall_req--;
            end else begin
                ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            mem_ready_i  = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rvalid_i = 1'b0;
            if (rq.size() != 0 && rq[0].due <= cyc + 1) begin
                r = rq.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(r.addr);
            end
            if (mem_rd_o && mem_ready_i && !rst_i) begin
                check_eq("req_addr", mem_addr_o, exp_addr(nreq));
                nreq++;
                r.addr = mem_addr_o;
                r.due  = cyc + 1 + lat;
                rq.push_back(r);
                if (rq.size() > max_outst) max_outst = rq.size();
            end
            if (valid_o) begin
                if (hold_prev) check_eq("hold_data", data_o, prev_data);
                if (!ready_i) begin
                    stall_seen++;
                end else begin
                    if (ncol < WIN_COLS) begin
                        check_eq("col_data", data_o, exp_col[ncol]);
                        check_eq("last", last_o, ncol == WIN_COLS - 1);
                    end else begin
                        check_eq("extra_col", ncol, WIN_COLS - 1);
                    end
                    if (last_o) last_hs_cyc = cyc + 1;
                    ncol++;
                end
                hold_prev = !ready_i;
                prev_data = data_o;
            end else begin
                hold_prev = 0;
            end
        end
    end

    task automatic launch(input logic [15:0] b, input logic [15:0] s, input int unsigned l,
                          input bit mr, input bit rr);
        win_base = b; win_stride = s; lat = l; mem_rand = mr; rdy_rand = rr;
        build_expected();
        ncol = 0; nreq = 0; stall_seen = 0; max_outst = 0; last_hs_cyc = 0;
        @(negedge clk);
        base_addr_i = b;
        stride_i    = s;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        base_addr_i = 16'($urandom);
        stride_i    = 16'($urandom);
        check_eq("busy_after_start", busy_o, 1);
        check_eq("rd_after_start", mem_rd_o, 1);
    endtask

    task automatic run_window(input logic [15:0] b, input logic [15:0] s, input int unsigned l,
                              input bit mr, input bit rr, input bit inject);
        bit seen_done = 0;
        launch(b, s, l, mr, rr);
        for (int unsigned t = 0; t < 4000 && !seen_done; t++) begin
            if (inject && t == 20) begin
                start_i     = 1'b1;
                base_addr_i = 16'h5555;
            end
            if (inject && t == 21) start_i = 1'b0;
            if (inject && t == 40) stall_req = 10;
            if (inject && t == 49) check_eq("credit_stall", mem_rd_o, 0);
            if (done_o) begin
                seen_done = 1;
                check_eq("done_timing", cyc, last_hs_cyc);
                check_eq("busy_at_done", busy_o, 0);
                check_eq("cols", ncol, WIN_COLS);
                check_eq("reqs", nreq, NREQ);
                check_eq("max_outst_le6", max_outst <= CREDITS, 1);
`ifdef REF_STREAM_STATS_EN
                check_eq("stall_cnt", stall_cnt_o, stall_seen);
`endif
            end
            @(negedge clk);
        end
        check_eq("done_seen", seen_done, 1);
        check_eq("done_pulse", done_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, mem_rd_o, 0);
        check_eq({tag, "_addr"}, mem_addr_o, 0);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_last"}, last_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_data"}, data_o, 0);
`ifdef REF_STREAM_STATS_EN
        check_eq({tag, "_stall"}, stall_cnt_o, 0);
`endif
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        stride_i    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);

        // Basic window with an ignored start and a 10-cycle downstream stall
        run_window(16'h0100, 16'd3, 1, 0, 0, 1);
        // Slow memory, random acceptance and random downstream ready
        run_window(16'($urandom), 16'($urandom_range(1, 300)), 5, 1, 1, 0);
        // Address wrap: first column reads FFFE, FFFF, 0000
        run_window(16'hFFFE, 16'd3, 2, 0, 0, 0);

        // Reset mid-window with reads still in flight
        launch(16'h2000, 16'd5, 5, 1, 0);
        for (int unsigned t = 0; t < 2000 && ncol < 7; t++) @(negedge clk);
        check_eq("reached_col7", ncol >= 7, 1);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_i = 1'b0;
        for (int unsigned t = 0; t < 50 && rq.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("stale_drained", rq.size(), 0);
        check_eq("stale_valid", valid_o, 0);
        check_eq("stale_busy", busy_o, 0);
        check_eq("stale_rd", mem_rd_o, 0);
        run_window(16'h0100, 16'd3, 3, 1, 0, 0);

        // Random windows
        for (int i = 0; i < 2; i++) begin
            run_window(16'($urandom), 16'($urandom), $urandom_range(1, 6), 1'($urandom), 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
